reg_file_checker: RTL and testbench

REG_FILE_CHECKER -- requirements
Module: reg_file_checker

---
 rtl/reg_file_checker.sv | 174 +++++++++++++++++
 tb/tb_reg_file_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_checker.sv
// Shadow register file fed by core writebacks, compared against a
// loadable expected table after halt or cycle-budget timeout.
module reg_file_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int INDEX_BITS  = 5,
  parameter int TEST_LENGTH = 100
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  wb_valid_i,
  input  logic [INDEX_BITS-1:0] wb_index_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  exp_write_i,
  input  logic [INDEX_BITS-1:0] exp_index_i,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic                  exp_care_i,
  input  logic [INDEX_BITS-1:0] dump_index_i,
  output logic [DATA_WIDTH-1:0] dump_expected_o,
  output logic [DATA_WIDTH-1:0] dump_actual_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  passed_o,
  output logic                  timed_out_o,
  output logic [INDEX_BITS:0]   mismatch_count_o,
  output logic [INDEX_BITS-1:0] first_mismatch_o
);

  localparam int CW  = $clog2(TEST_LENGTH) + 1;
  localparam int IW1 = INDEX_BITS + 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TEST_LENGTH - 1);
  localparam logic [IW1-1:0] NREGS = IW1'(NUM_REGS);
  localparam logic [INDEX_BITS-1:0] LAST_IDX =
    INDEX_BITS'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] exp_q    [NUM_REGS];
  logic [NUM_REGS-1:0]   care_q;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [IW1-1:0]        mm_q, mm_d;
  logic [INDEX_BITS-1:0] first_q, first_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  to_q, to_d;
  logic [DATA_WIDTH-1:0] dexp_q, dact_q;

  logic clr_sh, wb_en, exp_en, mm_hit;
  logic wb_rng, exp_rng, dump_rng;

  assign wb_rng   = {1'b0, wb_index_i} < NREGS;
  assign exp_rng  = {1'b0, exp_index_i} < NREGS;
  assign dump_rng = {1'b0, dump_index_i} < NREGS;

  assign mm_hit = care_q[idx_q] &&
                  (shadow_q[idx_q] != exp_q[idx_q]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mm_d    = mm_q;
    first_d = first_q;
    done_d  = done_q;
    pass_d  = pass_q;
    to_d    = to_q;
    clr_sh  = 1'b0;
    wb_en   = 1'b0;
    exp_en  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        exp_en = exp_write_i && exp_rng;
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          mm_d    = '0;
          first_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          clr_sh  = 1'b1;
        end
      end
      S_RUN: begin
        wb_en = wb_valid_i && wb_rng &&
                (wb_index_i != '0);
        cnt_d = cnt_q + 1'b1;
        if (halt_i || cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
          idx_d   = '0;
          to_d    = !halt_i;
        end
      end
      S_CHECK: begin
        if (mm_hit) begin
          mm_d = mm_q + 1'b1;
          if (mm_q == '0) first_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (mm_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mm_q    <= '0;
      first_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      dexp_q  <= '0;
      dact_q  <= '0;
      care_q  <= '1;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        exp_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      first_q <= first_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
      if (clr_sh) begin
        for (int i = 0; i < NUM_REGS; i++)
          shadow_q[i] <= '0;
      end else if (wb_en) begin
        shadow_q[wb_index_i] <= wb_data_i;
      end
      if (exp_en) begin
        exp_q[exp_index_i]  <= exp_data_i;
        care_q[exp_index_i] <= exp_care_i;
      end
      dexp_q <= dump_rng ? exp_q[dump_index_i] : '0;
      dact_q <= dump_rng ? shadow_q[dump_index_i] : '0;
    end
  end

  assign busy_o = (state_q == S_RUN) ||
                  (state_q == S_CHECK);
  assign done_o           = done_q;
  assign passed_o         = pass_q;
  assign timed_out_o      = to_q;
  assign mismatch_count_o = mm_q;
  assign first_mismatch_o = first_q;
  assign dump_expected_o  = dexp_q;
  assign dump_actual_o    = dact_q;

endmodule

// File: tb/tb_reg_file_checker.sv
// Randomized bench for reg_file_checker against a
// transaction-level model of the expected/shadow tables.
module tb_reg_file_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IB = 5;
  localparam int TL = 100;
  localparam int PL = TL + 40;

  logic          clk = 1'b0;
  logic          rst, start, halt;
  logic          wbv, ewr, ecare;
  logic [IB-1:0] wbi, ei, di;
  logic [DW-1:0] wbd, ed;
  logic [DW-1:0] d_exp, d_act;
  logic          busy, done, passed, tout;
  logic [IB:0]   mmc;
  logic [IB-1:0] first;

  reg_file_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .INDEX_BITS(IB), .TEST_LENGTH(TL)
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .start_i(start), .halt_i(halt),
    .wb_valid_i(wbv), .wb_index_i(wbi),
    .wb_data_i(wbd), .exp_write_i(ewr),
    .exp_index_i(ei), .exp_data_i(ed),
    .exp_care_i(ecare), .dump_index_i(di),
    .dump_expected_o(d_exp),
    .dump_actual_o(d_act),
    .busy_o(busy), .done_o(done),
    .passed_o(passed), .timed_out_o(tout),
    .mismatch_count_o(mmc),
    .first_mismatch_o(first)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, got, want);
    end
  endtask

  logic [DW-1:0] m_exp [NR];
  logic [DW-1:0] m_sh  [NR];
  bit            m_care[NR];

  bit            p_v [PL];
  int            p_i [PL];
  logic [DW-1:0] p_d [PL];
  bit            p_ew[PL];

  task automatic idle_in();
    start = 0; halt = 0; wbv = 0; wbi = '0;
    wbd = '0; ewr = 0; ei = '0; ed = '0;
    ecare = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_exp[i] = '0; m_sh[i] = '0; m_care[i] = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1; idle_in();
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic clear_plan();
    for (int c = 0; c < PL; c++) begin
      p_v[c] = 0; p_i[c] = 0;
      p_d[c] = '0; p_ew[c] = 0;
    end
  endtask

  task automatic rand_plan();
    for (int c = 0; c < PL; c++) begin
      p_v[c]  = ($urandom_range(0, 1) == 1);
      p_i[c]  = $urandom_range(0, NR - 1);
      p_d[c]  = ($urandom_range(0, 3) != 0) ?
                m_exp[p_i[c]] : $urandom;
      p_ew[c] = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic load(input int i,
                      input logic [DW-1:0] d,
                      input bit c);
    ewr = 1; ei = IB'(i); ed = d; ecare = c;
    @(negedge clk);
    ewr = 0;
    m_exp[i] = d; m_care[i] = c;
  endtask

  task automatic dump_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      di = IB'(i);
      @(negedge clk);
      chk({tag, "_act"}, d_act, m_sh[i]);
      chk({tag, "_exp"}, d_exp, m_exp[i]);
    end
  endtask

  task automatic run_test(input string tag,
                          input int halt_at);
    int  len, n_mm, f_mm;
    bit  exp_to;
    bit  hit;
    hit    = (halt_at >= 0) && (halt_at < TL);
    len    = hit ? halt_at + 1 : TL;
    exp_to = !hit;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < NR; i++) m_sh[i] = '0;
    for (int c = 0; c < len + 34; c++) begin
      chk({tag, "_busy"}, busy, (c < len + 32));
      if (c >= len + 31)
        chk({tag, "_done"}, done, (c >= len + 32));
      wbv  = (c < PL) && p_v[c];
      wbi  = IB'((c < PL) ? p_i[c] : 0);
      wbd  = (c < PL) ? p_d[c] : '0;
      halt = (c == halt_at);
      ewr  = (c < PL) && p_ew[c] &&
             (c < len + 32);
      ei   = IB'($urandom_range(0, NR - 1));
      ed   = $urandom;
      ecare = $urandom_range(0, 1) == 1;
      if (c < len && wbv && wbi != 0)
        m_sh[wbi] = wbd;
      @(negedge clk);
    end
    idle_in();
    n_mm = 0; f_mm = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_care[i] && m_sh[i] != m_exp[i]) begin
        if (n_mm == 0) f_mm = i;
        n_mm++;
      end
    end
    chk({tag, "_pass"}, passed, (n_mm == 0));
    chk({tag, "_mmc"}, mmc, n_mm);
    chk({tag, "_first"}, first, f_mm);
    chk({tag, "_tout"}, tout, exp_to);
    dump_all(tag);
  endtask

  initial begin
    rst = 1; idle_in(); di = '0;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", passed, 0);
    chk("rst_tout", tout, 0);
    chk("rst_mmc", mmc, 0);
    chk("rst_first", first, 0);
    chk("rst_dact", d_act, 0);
    chk("rst_dexp", d_exp, 0);

    for (int i = 0; i < NR; i++) m_care[i] = 0;
    for (int i = 0; i < NR; i++) load(i, '0, 0);
    load(11, 32'h0000_1000, 1);
    load(12, 32'h8000_0000, 1);
    clear_plan();
    p_v[3] = 1; p_i[3] = 11; p_d[3] = 32'h0000_1000;
    p_v[5] = 1; p_i[5] = 0;  p_d[5] = 32'hDEAD_BEEF;
    p_v[20] = 1; p_i[20] = 12;
    p_d[20] = 32'h8000_0000;
    run_test("basic", 20);
    chk("basic_pass1", passed, 1);

    load(11, '0, 1);
    load(13, 32'hFFFF_F000, 1);
    clear_plan();
    p_v[2] = 1; p_i[2] = 12; p_d[2] = 32'h8000_0001;
    p_v[4] = 1; p_i[4] = 13; p_d[4] = '0;
    run_test("mism", 10);
    chk("mism_cnt2", mmc, 2);
    chk("mism_first12", first, 12);

    clear_plan();
    run_test("tmo", -1);
    chk("tmo_flag", tout, 1);
    run_test("tmo_edge", TL - 1);

    do_reset();
    load(5, '0, 0);
    clear_plan();
    p_v[1] = 1; p_i[1] = 5; p_d[1] = 32'h1234_5678;
    p_ew[2] = 1; p_ew[8] = 1; p_ew[30] = 1;
    run_test("nocare", 40);

    for (int t = 0; t < 6; t++) begin
      int h;
      for (int k = 0; k < 6; k++)
        load($urandom_range(0, NR - 1), $urandom,
             $urandom_range(0, 1) == 1);
      rand_plan();
      h = ($urandom_range(0, 3) == 0) ? -1 :
          $urandom_range(0, TL - 1);
      run_test("rnd", h);
    end

    load(7, 32'h55, 0);
    start = 1;
    @(negedge clk);
    start = 0; halt = 1;
    wbv = 1; wbi = 9; wbd = 32'hABCD;
    @(negedge clk);
    idle_in();
    repeat (10) @(negedge clk);
    chk("midchk_busy", busy, 1);
    do_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mmc", mmc, 0);
    dump_all("midrst");
    clear_plan();
    p_v[0] = 1; p_i[0] = 7; p_d[0] = 32'h77;
    p_v[6] = 1; p_i[6] = 3; p_d[6] = 32'h1;
    run_test("fresh", 15);
    chk("fresh_mmc2", mmc, 2);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
